// File: rtl/acc_serializer_pkg.sv
// Shared types and helpers for the accumulator serializer.
// Saturation bounds are only used when ACC_SERIALIZER_SAT_EN is defined.
package acc_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int lane_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bounds are held as 64-bit signed values, so lanes wider than 64 bits are not supported.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/acc_sat_narrow.sv
// Combinational DATA_WIDTH -> OUT_WIDTH narrower.
// ACC_SERIALIZER_SAT_EN selects signed clamping instead of plain truncation.
module acc_sat_narrow
  import acc_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] lane,
  output logic [OUT_WIDTH-1:0]  narrow
);

  generate
    if (OUT_WIDTH == DATA_WIDTH) begin : g_pass
      assign narrow = lane;
    end else begin : g_narrow
`ifdef ACC_SERIALIZER_SAT_EN
      localparam logic signed [63:0] HI = sat_max(OUT_WIDTH);
      localparam logic signed [63:0] LO = sat_min(OUT_WIDTH);
      logic signed [63:0] lane_ext;
      assign lane_ext = 64'($signed(lane));
      always_comb begin
        if (lane_ext > HI)      narrow = HI[OUT_WIDTH-1:0];
        else if (lane_ext < LO) narrow = LO[OUT_WIDTH-1:0];
        else                    narrow = lane_ext[OUT_WIDTH-1:0];
      end
`else
      assign narrow = OUT_WIDTH'(lane);
`endif
    end
  endgenerate

endmodule

// File: rtl/acc_serializer.sv
// Captures NUM_LANES accumulator lanes and streams them, one per ready/valid transfer,
// to a single-port buffer with auto-incremented addresses. Optional: ACC_SERIALIZER_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start; captures lanes and optionally loads base address
// SEND  | wr_en high, presenting head lane; shifts on each accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE
module acc_serializer
  import acc_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 10,
  parameter int ADDR_WIDTH = 7,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic                            addr_load,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic                            wr_ready,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [OUT_WIDTH-1:0]            wr_data,
  output logic                            busy,
  output logic                            done,
  output logic                            start_drop
);

  localparam int CW = lane_cnt_width(NUM_LANES);
  localparam int SW = NUM_LANES * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);

  state_t                state;
  logic [SW-1:0]         shreg;
  logic [CW-1:0]         lane_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  xfer;

  assign xfer    = wr_en && wr_ready;
  assign wr_addr = addr_cnt;

  // Lane 0 sits in the MSB slice, so the head is always the top DATA_WIDTH bits.
  acc_sat_narrow #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_narrow (
    .lane  (shreg[SW-1 -: DATA_WIDTH]),
    .narrow(wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      lane_cnt   <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      start_drop <= start && (state != IDLE);
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg    <= data_in;
            lane_cnt <= '0;
            if (addr_load) addr_cnt <= base_addr;
            wr_en    <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            shreg    <= shreg << DATA_WIDTH;
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            lane_cnt <= lane_cnt + CW'(1);
            if (lane_cnt == LAST) begin
              wr_en <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_serializer.sv
// Self-checking bench for acc_serializer: table-driven bursts with a write scoreboard,
// plus hand sequences for collision, mid-burst reset and the 16-bit narrowing instance.
module tb_acc_serializer;

  localparam int DW = 32;
  localparam int NL = 10;
  localparam int AW = 7;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, addr_load, wr_ready;
  logic [NL*DW-1:0] data_in;
  logic [AW-1:0]   base_addr;
  logic            wr_en, busy, done, start_drop;
  logic [AW-1:0]   wr_addr;
  logic [OW-1:0]   wr_data;

  logic            s_start, s_addr_load, s_wr_ready;
  logic [3*DW-1:0] s_data_in;
  logic [AW-1:0]   s_base_addr;
  logic            s_wr_en, s_busy, s_done, s_start_drop;
  logic [AW-1:0]   s_wr_addr;
  logic [15:0]     s_wr_data;

  always #5 clk = ~clk;

  acc_serializer #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .addr_load(addr_load),
    .base_addr(base_addr), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .start_drop(start_drop)
  );

  acc_serializer #(.DATA_WIDTH(DW), .NUM_LANES(3), .ADDR_WIDTH(AW), .OUT_WIDTH(16)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .data_in(s_data_in), .addr_load(s_addr_load),
    .base_addr(s_base_addr), .wr_ready(s_wr_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .busy(s_busy), .done(s_done), .start_drop(s_start_drop)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [OW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    bit            load;
    int            seed;
    int            stall_lo;
    int            stall_hi;
    int            done_cyc;
  } vec_t;

  wr_t           sb[$];
  logic [AW-1:0] model_addr;
  bit            mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every presented word must match the scoreboard head; it is retired only on a transfer.
  always @(negedge clk) begin
    if (mon_on && wr_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", wr_addr, wr_data);
      end else begin
        check("wr_addr", wr_addr, sb[0].addr);
        check("wr_data", wr_data, sb[0].data);
        if (wr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic set_lanes(input int seed);
    for (int k = 0; k < NL; k++) data_in[(NL-1-k)*DW +: DW] = DW'(seed + k);
  endtask

  task automatic push_burst(input logic [AW-1:0] base, input bit load, input int seed);
    wr_t e;
    if (load) model_addr = base;
    for (int k = 0; k < NL; k++) begin
      e.addr = model_addr;
      e.data = OW'(seed + k);
      sb.push_back(e);
      model_addr = model_addr + AW'(1);
    end
  endtask

  // Called at #1 after an edge: that cycle is cycle 0 of the burst.
  task automatic run_vec(input vec_t v);
    set_lanes(v.seed);
    base_addr = v.base;
    addr_load = v.load;
    start     = 1'b1;
    wr_ready  = 1'b1;
    push_burst(v.base, v.load, v.seed);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    start     = 1'b0;
    addr_load = 1'b0;
    for (int c = 1; c <= v.done_cyc; c++) begin
      wr_ready = !(c >= v.stall_lo && c <= v.stall_hi);
      @(negedge clk);
      check("busy", busy, 1'b1);
      check("done", done, c == v.done_cyc);
      check("wr_en", wr_en, c < v.done_cyc);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{7'd5,   1'b1, 100, 0, -1, 11};
    vecs[1] = '{7'd124, 1'b1, 200, 0, -1, 11};
    vecs[2] = '{7'd0,   1'b0, 300, 0, -1, 11};
    vecs[3] = '{7'd5,   1'b1, 400, 3,  5, 14};

    rst = 1'b1; start = 1'b0; addr_load = 1'b0; wr_ready = 1'b0;
    data_in = '0; base_addr = '0;
    s_start = 1'b0; s_addr_load = 1'b0; s_wr_ready = 1'b0;
    s_data_in = '0; s_base_addr = '0;
    model_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_start_drop", start_drop, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Start collision: a second start in cycle 4 must only produce start_drop in cycle 5.
    set_lanes(500);
    base_addr = 7'd20; addr_load = 1'b1; start = 1'b1; wr_ready = 1'b1;
    push_burst(7'd20, 1'b1, 500);
    @(posedge clk); #1;
    start = 1'b0; addr_load = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 4) begin
        set_lanes(900); base_addr = 7'd99; addr_load = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0; addr_load = 1'b0;
      end
      @(negedge clk);
      check("coll_start_drop", start_drop, c == 5);
      check("coll_done", done, c == 11);
      check("coll_busy", busy, 1'b1);
      @(posedge clk); #1;
    end

    // Reset in cycle 6 of a burst: outputs clear immediately and no done follows.
    set_lanes(600);
    base_addr = 7'd30; addr_load = 1'b1; start = 1'b1;
    push_burst(7'd30, 1'b1, 600);
    @(posedge clk); #1;
    start = 1'b0; addr_load = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mrst_wr_en", wr_en, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_wr_addr", wr_addr, 0);
    check("mrst_done", done, 1'b0);
    mon_on = 1'b0;
    check("mrst_sb_left", sb.size(), NL - 5);
    sb.delete();
    model_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    run_vec('{7'd40, 1'b1, 700, 0, -1, 11});

    // 16-bit narrowing instance.
    s_data_in   = {32'h0001_2345, 32'hFFFF_0000, 32'h0000_0123};
    s_base_addr = 7'd10; s_addr_load = 1'b1; s_start = 1'b1; s_wr_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_addr_load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      logic [15:0] exp_d;
`ifdef ACC_SERIALIZER_SAT_EN
      exp_d = (c == 1) ? 16'h7FFF : (c == 2) ? 16'h8000 : 16'h0123;
`else
      exp_d = (c == 1) ? 16'h2345 : (c == 2) ? 16'h0000 : 16'h0123;
`endif
      @(negedge clk);
      if (c <= 3) begin
        check("narrow_data", s_wr_data, exp_d);
        check("narrow_addr", s_wr_addr, 7'(9 + c));
      end
      check("narrow_done", s_done, c == 4);
      @(posedge clk); #1;
    end

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
